// File: rtl/cmp_scan_ctrl.sv
// Sequencer that time-shares one external active-low 8-bit equality comparator across
// a bank of programmable match entries, reporting the lowest matching index or a miss.
module cmp_scan_ctrl #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             load_en,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [7:0]       load_data,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       key,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output logic [7:0]       cmp_a,
  output logic [7:0]       cmp_b,
  output logic             cmp_e_n,
  input  logic             cmp_ab_n
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             entry_q [N_ENTRIES];
  logic [7:0]             entry_d [N_ENTRIES];
  logic [N_ENTRIES-1:0]   valid_q, valid_d;
  logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
  logic [7:0]             key_q, key_d;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
  logic                   match;
  logic                   last_entry;

  assign last_entry = (scan_idx_q == IDX_W'(N_ENTRIES - 1));
  // Comparator result is only meaningful while the enable is asserted.
  assign match      = (state_q == S_SCAN) && !cmp_e_n && !cmp_ab_n;

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      entry_q    <= '{default: '0};
      valid_q    <= '0;
      scan_idx_q <= '0;
      key_q      <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      valid_q    <= valid_d;
      scan_idx_q <= scan_idx_d;
      key_q      <= key_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN: begin
        if (abort)                    state_d = S_IDLE;
        else if (match || last_entry) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    entry_d    = entry_q;
    valid_d    = valid_q;
    scan_idx_d = scan_idx_q;
    key_d      = key_q;
    hit_d      = hit_q;
    hit_idx_d  = hit_idx_q;
    // Bank writes are independent of the scan; load beats clear on the same entry.
    if (load_en) begin
      entry_d[load_idx] = load_data;
      valid_d[load_idx] = 1'b1;
    end else if (clr_en) begin
      valid_d[load_idx] = 1'b0;
    end
    case (state_q)
      S_IDLE: if (start) begin
        key_d      = key;
        scan_idx_d = '0;
        hit_d      = 1'b0;
        hit_idx_d  = '0;
      end
      S_SCAN: if (!abort) begin
        if (match) begin
          hit_d     = 1'b1;
          hit_idx_d = scan_idx_q;
        end else if (last_entry) begin
          hit_d     = 1'b0;
          hit_idx_d = '0;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    hit     = hit_q;
    hit_idx = hit_idx_q;
    cmp_a   = key_q;
    cmp_b   = entry_q[0];
    cmp_e_n = 1'b1;
    if (state_q == S_SCAN) begin
      cmp_b   = entry_q[scan_idx_q];
      cmp_e_n = !valid_q[scan_idx_q];
    end
  end

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Self-checking bench for cmp_scan_ctrl: directed scenarios then randomized scans,
// checked against an array model of the entry bank and first-hit search.
module tb_cmp_scan_ctrl;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         sys_rst_n;
  logic         load_en, clr_en, start, abort;
  logic [W-1:0] load_idx;
  logic [7:0]   load_data, key;
  logic         busy, done, hit, cmp_e_n, cmp_ab_n;
  logic [W-1:0] hit_idx;
  logic [7:0]   cmp_a, cmp_b;
  logic         junk = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rd [N];
  logic       rv [N];

  always #5 clk = ~clk;
  always @(negedge clk) junk <= 1'($urandom);

  // External comparator: disabled output is arbitrary and must never be trusted.
  assign cmp_ab_n = cmp_e_n ? junk : (cmp_a != cmp_b);

  cmp_scan_ctrl #(.N_ENTRIES(N)) dut (
    .sysclk(clk), .sys_rst_n(sys_rst_n), .load_en(load_en), .clr_en(clr_en),
    .load_idx(load_idx), .load_data(load_data), .start(start), .abort(abort),
    .key(key), .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_e_n(cmp_e_n), .cmp_ab_n(cmp_ab_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int idx, input logic [7:0] v, input bit with_clr);
    @(negedge clk);
    load_en = 1'b1; clr_en = with_clr; load_idx = W'(idx); load_data = v;
    @(negedge clk);
    load_en = 1'b0; clr_en = 1'b0;
    rd[idx] = v; rv[idx] = 1'b1;
  endtask

  task automatic do_clr(input int idx);
    @(negedge clk);
    clr_en = 1'b1; load_idx = W'(idx);
    @(negedge clk);
    clr_en = 1'b0;
    rv[idx] = 1'b0;
  endtask

  // Scan with optional abort in slot abort_at and optional bank write in slot ld_at (-1 = none).
  task automatic run_scan(input logic [7:0] k, input int abort_at, input int ld_at,
                          input int ld_i, input logic [7:0] ld_v);
    bit matched;
    @(negedge clk);
    start = 1'b1; key = k;
    @(negedge clk);
    start = 1'b0; key = ~k;
    chk("busy_after_start", busy, 1);
    chk("hit_cleared", hit, 0);
    for (int i = 0; i < N; i++) begin
      chk("cmp_e_n_slot", cmp_e_n, !rv[i]);
      chk("cmp_a_slot", cmp_a, k);
      chk("cmp_b_slot", cmp_b, rd[i]);
      chk("done_in_scan", done, 0);
      matched = rv[i] && (rd[i] == k);
      if (i == ld_at) begin
        load_en = 1'b1; load_idx = W'(ld_i); load_data = ld_v;
      end
      if (i == abort_at) abort = 1'b1;
      @(negedge clk);
      load_en = 1'b0; abort = 1'b0;
      if (i == ld_at) begin rd[ld_i] = ld_v; rv[ld_i] = 1'b1; end
      if (i == abort_at) begin
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hit", hit, 0);
        return;
      end
      if (matched || i == N - 1) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_cmp_e_n", cmp_e_n, 1);
        chk("hit", hit, matched);
        chk("hit_idx", hit_idx, matched ? i : 0);
        start = 1'b1; key = 8'h5A;
        @(negedge clk);
        start = 1'b0;
        chk("done_single", done, 0);
        chk("start_in_done_ignored", busy, 0);
        chk("key_kept", cmp_a, k);
        chk("hit_held", hit, matched);
        chk("hit_idx_held", hit_idx, matched ? i : 0);
        return;
      end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0; load_en = 0; clr_en = 0; start = 0; abort = 0;
    load_idx = '0; load_data = '0; key = '0;
    for (int i = 0; i < N; i++) begin rd[i] = '0; rv[i] = 1'b0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);     chk("rst_hit_idx", hit_idx, 0);
    chk("rst_cmp_e_n", cmp_e_n, 1);
    chk("rst_cmp_a", cmp_a, 0); chk("rst_cmp_b", cmp_b, 0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < N; i++) do_load(i, 8'h10 + 8'(i), 1'b0);
    run_scan(8'h13, -1, -1, 0, 0);
    run_scan(8'h55, -1, -1, 0, 0);

    do_load(2, 8'hA5, 1'b0);
    do_load(6, 8'hA5, 1'b0);
    do_clr(2);
    run_scan(8'hA5, -1, -1, 0, 0);

    run_scan(8'h17, 1, -1, 0, 0);
    run_scan(8'h17, -1, -1, 0, 0);

    run_scan(8'h30, -1, 4, 4, 8'h30);
    run_scan(8'h30, -1, -1, 0, 0);

    do_load(1, 8'h30, 1'b1);
    run_scan(8'h30, -1, -1, 0, 0);

    @(negedge clk); start = 1'b1; key = 8'h99;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);  chk("async_rst_done", done, 0);
    chk("async_rst_hit", hit, 0);    chk("async_rst_cmp_e_n", cmp_e_n, 1);
    chk("async_rst_cmp_a", cmp_a, 0); chk("async_rst_cmp_b", cmp_b, 0);
    for (int i = 0; i < N; i++) begin rd[i] = '0; rv[i] = 1'b0; end
    @(negedge clk); sys_rst_n = 1'b1;
    run_scan(8'h00, -1, -1, 0, 0);

    for (int it = 0; it < 30; it++) begin
      int nl, ab, la;
      logic [7:0] k;
      nl = int'($urandom_range(0, 3));
      for (int j = 0; j < nl; j++)
        do_load(int'($urandom_range(0, N - 1)), 8'h40 + 8'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 2) == 0) do_clr(int'($urandom_range(0, N - 1)));
      k  = 8'h40 + 8'($urandom_range(0, 4));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      la = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_scan(k, ab, la, int'($urandom_range(0, N - 1)), 8'h40 + 8'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
